// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin arbiter onto a single slave bus with timeout completion
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_rd,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_wrmask,
    input  logic [31:0] m0_wdata,
    input  logic        m1_rd,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_wrmask,
    input  logic [31:0] m1_wdata,
    output logic        m0_rd_valid,
    output logic        m0_wr_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_rd_valid,
    output logic        m1_wr_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_rd,
    output logic        s_wr,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wrmask,
    output logic [31:0] s_wdata,
    input  logic        s_rd_valid,
    input  logic        s_wr_valid,
    input  logic [31:0] s_rdata
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;

    logic        req0, req1;
    logic        g_rd, g_wr;
    logic [31:0] g_addr, g_wdata;
    logic [3:0]  g_wrmask;
    logic        cmp_rd_v, cmp_wr_v, cmp_err;
    logic [31:0] cmp_rdata;

    assign req0     = m0_rd | m0_wr;
    assign req1     = m1_rd | m1_wr;
    assign g_rd     = gnt_q ? m1_rd     : m0_rd;
    assign g_wr     = gnt_q ? m1_wr     : m0_wr;
    assign g_addr   = gnt_q ? m1_addr   : m0_addr;
    assign g_wrmask = gnt_q ? m1_wrmask : m0_wrmask;
    assign g_wdata  = gnt_q ? m1_wdata  : m0_wdata;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        s_rd      = 1'b0;
        s_wr      = 1'b0;
        s_addr    = 32'h0;
        s_wrmask  = 4'h0;
        s_wdata   = 32'h0;
        cmp_rd_v  = 1'b0;
        cmp_wr_v  = 1'b0;
        cmp_err   = 1'b0;
        cmp_rdata = 32'h0;
        case (state_q)
            IDLE: begin
                cnt_d = 16'h0;
                if (req0 || req1) begin
                    // On a tie the master that did not win last time gets the bus
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    last_d  = gnt_d;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_wr     = g_wr;
                s_rd     = g_rd & ~g_wr;
                s_addr   = g_addr;
                s_wrmask = g_wrmask;
                s_wdata  = g_wdata;
                if (!(g_rd || g_wr)) begin
                    state_d = IDLE;
                end else if (s_rd_valid || s_wr_valid) begin
                    cmp_rd_v  = s_rd_valid;
                    cmp_wr_v  = s_wr_valid;
                    cmp_rdata = s_rdata;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    cmp_err  = 1'b1;
                    cmp_rd_v = ~g_wr;
                    cmp_wr_v = g_wr;
                    state_d  = IDLE;
                end else begin
                    cmp_rdata = s_rdata;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign m0_rd_valid = cmp_rd_v & ~gnt_q;
    assign m0_wr_valid = cmp_wr_v & ~gnt_q;
    assign m0_err      = cmp_err  & ~gnt_q;
    assign m0_rdata    = gnt_q ? 32'h0 : cmp_rdata;
    assign m1_rd_valid = cmp_rd_v & gnt_q;
    assign m1_wr_valid = cmp_wr_v & gnt_q;
    assign m1_err      = cmp_err  & gnt_q;
    assign m1_rdata    = gnt_q ? cmp_rdata : 32'h0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - scoreboard bench for bus_arbiter
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wrmask, m1_wrmask;
    logic        m0_rd_valid, m0_wr_valid, m0_err, m1_rd_valid, m1_wr_valid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_rd, s_wr, s_rd_valid, s_wr_valid;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wrmask;

    int errors = 0;
    int checks = 0;
    logic [69:0] exp_cmp[$];
    logic [69:0] exp_bus[$];
    logic        prev_bus = 1'b0;

    logic [69:0] cmp_act, bus_act;
    assign cmp_act = {m0_rd_valid, m0_wr_valid, m0_err, m0_rdata,
                      m1_rd_valid, m1_wr_valid, m1_err, m1_rdata};
    assign bus_act = {s_rd, s_wr, s_addr, s_wrmask, s_wdata};

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wrmask(m0_wrmask), .m0_wdata(m0_wdata),
        .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wrmask(m1_wrmask), .m1_wdata(m1_wdata),
        .m0_rd_valid(m0_rd_valid), .m0_wr_valid(m0_wr_valid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_rd_valid(m1_rd_valid), .m1_wr_valid(m1_wr_valid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_rd(s_rd), .s_wr(s_wr), .s_addr(s_addr), .s_wrmask(s_wrmask), .s_wdata(s_wdata),
        .s_rd_valid(s_rd_valid), .s_wr_valid(s_wr_valid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [69:0] mk_cmp(input int m, input logic rv, input logic wv,
                                           input logic er, input logic [31:0] rd);
        logic [34:0] v;
        v = {rv, wv, er, rd};
        return (m == 0) ? {v, 35'h0} : {35'h0, v};
    endfunction

    function automatic logic [69:0] mk_bus(input logic rd, input logic wr, input logic [31:0] a,
                                           input logic [3:0] k, input logic [31:0] d);
        return {rd, wr, a, k, d};
    endfunction

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] k, input logic [31:0] d);
        if (m == 0) begin
            m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wrmask = k; m0_wdata = d;
        end else begin
            m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wrmask = k; m1_wdata = d;
        end
    endtask

    // Monitor: completions and slave-bus transaction starts are matched against queued expectations
    always @(negedge clk) begin
        logic [69:0] e;
        if (m0_rd_valid || m0_wr_valid || m1_rd_valid || m1_wr_valid) begin
            if (exp_cmp.size() == 0) begin
                chk("unexpected_completion", cmp_act, 70'h0);
            end else begin
                e = exp_cmp.pop_front();
                chk("completion", cmp_act, e);
            end
        end
        if ((s_rd || s_wr) && !prev_bus) begin
            if (exp_bus.size() == 0) begin
                chk("unexpected_bus_start", bus_act, 70'h0);
            end else begin
                e = exp_bus.pop_front();
                chk("bus_start", bus_act, e);
            end
        end
        prev_bus <= s_rd | s_wr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);
        s_rd_valid = 0; s_wr_valid = 0; s_rdata = 0;
        #1;
        chk("reset_outputs", cmp_act, 70'h0);
        chk("reset_bus", bus_act, 70'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Slave valid in IDLE is ignored
        tick();
        s_rd_valid = 1; s_rdata = 32'hFFFFFFFF;
        #2 chk("idle_valid_ignored", cmp_act, 70'h0);

        // Single m0 read, response in 2nd BUSY cycle
        tick();
        s_rd_valid = 0; s_rdata = 0;
        set_m(0, 1, 0, 32'h100, 0, 0);
        exp_bus.push_back(mk_bus(1, 0, 32'h100, 0, 0));
        #2 chk("latency_cycle_n", 70'(s_rd), 70'(0));
        tick();
        #2 chk("latency_cycle_n1", 70'(s_rd), 70'(1));
        tick();
        s_rd_valid = 1; s_rdata = 32'hDEADBEEF;
        exp_cmp.push_back(mk_cmp(0, 1, 0, 0, 32'hDEADBEEF));
        tick();
        s_rd_valid = 0; s_rdata = 0;
        set_m(0, 0, 0, 0, 0, 0);

        // Fresh reset, then both masters write continuously: grants alternate m0,m1,m0,m1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_m(0, 0, 1, 32'h200, 4'h3, 32'h11111111);
        set_m(1, 0, 1, 32'h300, 4'hC, 32'h22222222);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_bus.push_back(mk_bus(0, 1, 32'h200, 4'h3, 32'h11111111));
            else            exp_bus.push_back(mk_bus(0, 1, 32'h300, 4'hC, 32'h22222222));
            tick();
            s_wr_valid = 1;
            exp_cmp.push_back(mk_cmp(i % 2, 0, 1, 0, 0));
            tick();
            s_wr_valid = 0;
        end
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);

        // m1 read times out in the 4th BUSY cycle with rdata forced to 0
        tick();
        set_m(1, 1, 0, 32'h400, 0, 0);
        s_rdata = 32'hCAFEF00D;
        exp_bus.push_back(mk_bus(1, 0, 32'h400, 0, 0));
        tick(); tick(); tick(); tick();
        exp_cmp.push_back(mk_cmp(1, 1, 0, 1, 0));
        tick();
        #2 chk("timeout_then_idle", 70'({s_rd, s_wr}), 70'(0));
        set_m(1, 0, 0, 0, 0, 0);
        s_rdata = 0;

        // Slave response coinciding with the timeout cycle wins
        tick();
        set_m(0, 1, 0, 32'h500, 0, 0);
        exp_bus.push_back(mk_bus(1, 0, 32'h500, 0, 0));
        tick(); tick(); tick(); tick();
        s_rd_valid = 1; s_rdata = 32'h12345678;
        exp_cmp.push_back(mk_cmp(0, 1, 0, 0, 32'h12345678));
        tick();
        s_rd_valid = 0; s_rdata = 0;
        set_m(0, 0, 0, 0, 0, 0);

        // rd+wr together is a write only
        tick();
        set_m(0, 1, 1, 32'h600, 4'hF, 32'hA5A5A5A5);
        exp_bus.push_back(mk_bus(0, 1, 32'h600, 4'hF, 32'hA5A5A5A5));
        tick();
        s_wr_valid = 1;
        exp_cmp.push_back(mk_cmp(0, 0, 1, 0, 0));
        tick();
        s_wr_valid = 0;
        set_m(0, 0, 0, 0, 0, 0);

        // Reset mid-BUSY drops the bus without an edge; tie afterwards goes to m0
        tick();
        set_m(0, 1, 0, 32'h700, 0, 0);
        set_m(1, 1, 0, 32'h800, 0, 0);
        tick();
        chk("pre_reset_grant_m1", 70'({s_rd, s_addr}), 70'({1'b1, 32'h800}));
        s_rd_valid = 1; s_rdata = 32'h55AA55AA;
        #1 rst = 1'b1;
        #1;
        chk("async_reset_bus", bus_act, 70'h0);
        chk("async_reset_outputs", cmp_act, 70'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        s_rd_valid = 0; s_rdata = 0;
        exp_bus.push_back(mk_bus(1, 0, 32'h700, 0, 0));
        tick();
        s_rd_valid = 1; s_rdata = 32'h0BADCAFE;
        exp_cmp.push_back(mk_cmp(0, 1, 0, 0, 32'h0BADCAFE));
        tick();
        s_rd_valid = 0; s_rdata = 0;
        set_m(0, 0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0, 0);

        tick(); tick();
        chk("cmp_queue_drained", 70'(exp_cmp.size()), 70'(0));
        chk("bus_queue_drained", 70'(exp_bus.size()), 70'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
